// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4-Lite memory responder.
//   AXI_RESP_OKAY / AXI_RESP_DECERR : response codes driven on bresp/rresp
//   ADDR_LSB                        : byte-address bits below the word index
//   wr_state_e / rd_state_e         : write and read channel FSM states
//   resp_code()                     : maps an in-range flag to a response code
package axi_mem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned ADDR_LSB = 2;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic [1:0] resp_code(input logic ok);
    return ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Single-clock word memory with a byte-enabled write port and a registered
// read port. A read and write of the same word on one edge returns the old
// contents (read-before-write).
//   clk   : clock
//   we    : write enable, waddr/wdata/wbe : write word index, data, byte enables
//   re    : read enable, raddr : read word index
//   rdata : registered read data, updated only when re=1
module bram_be #(
  parameter  int unsigned DEPTH  = 1024,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite responder backed by a byte-enabled word memory. One outstanding
// transaction per direction; read and write channels run independently.
// Optional macro AXI_MEM_DECERR_EN: out-of-range accesses answer DECERR
// (writes dropped, reads return zero). Without it addresses wrap modulo
// MEM_DEPTH words and every response is OKAY.
// Ports:
//   clk, reset_n                        : clock, async active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b*     : write address, data, response
//   s_axi_ar* / s_axi_r*                : read address, data/response
//   s_axi_awprot / s_axi_arprot         : accepted and ignored
module axi4_lite_slave_mem
  import axi_mem_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH          = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = DW / 8;

`ifdef AXI_MEM_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  function automatic logic addr_in_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    return (a >> (ADDR_LSB + IDX_W)) == '0;
  endfunction

  // Readies stay low until the first edge after reset release.
  logic rdy_en;

  wr_state_e w_state, w_state_next;
  rd_state_e r_state, r_state_next;

  logic              aw_full, w_full;
  logic [IDX_W-1:0]  aw_idx;
  logic              aw_ok;
  logic [DW-1:0]     w_data;
  logic [STRB_W-1:0] w_strb;
  logic [1:0]        b_resp;
  logic              r_err;

  logic              mem_we, mem_re;
  logic [DW-1:0]     mem_q;

  logic aw_hs, w_hs, b_hs, ar_hs;

  assign s_axi_awready = rdy_en && (w_state == W_IDLE) && !aw_full;
  assign s_axi_wready  = rdy_en && (w_state == W_IDLE) && !w_full;
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bresp   = b_resp;

  assign s_axi_arready = rdy_en && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rresp   = resp_code(!r_err);
  assign s_axi_rdata   = (s_axi_rvalid && !r_err) ? mem_q : '0;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign b_hs  = s_axi_bvalid  && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // ---------------------------------------------------------------- write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) w_state <= W_IDLE;
    else          w_state <= w_state_next;
  end

  // Commit happens on the edge that moves IDLE -> RESP, so bvalid and the
  // memory write land together.
  always_comb begin
    w_state_next = w_state;
    mem_we       = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (aw_full && w_full) begin
          w_state_next = W_RESP;
          mem_we       = aw_ok;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en  <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      aw_ok   <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      b_resp  <= AXI_RESP_OKAY;
    end else begin
      rdy_en <= 1'b1;
      if (b_hs) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_idx  <= s_axi_awaddr[ADDR_LSB +: IDX_W];
          aw_ok   <= !DECERR_EN || addr_in_range(s_axi_awaddr);
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= s_axi_wdata;
          w_strb <= s_axi_wstrb;
        end
      end
      if (mem_we || (w_state == W_IDLE && aw_full && w_full)) begin
        b_resp <= resp_code(aw_ok);
      end
    end
  end

  // ----------------------------------------------------------------- read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= R_IDLE;
    else          r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    mem_re       = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_next = R_DATA;
          mem_re       = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (ar_hs) begin
      r_err <= DECERR_EN && !addr_in_range(s_axi_araddr);
    end
  end

  // ------------------------------------------------------------- storage
  bram_be #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (DW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (aw_idx),
    .wdata (w_data),
    .wbe   (w_strb),
    .re    (mem_re),
    .raddr (s_axi_araddr[ADDR_LSB +: IDX_W]),
    .rdata (mem_q)
  );

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

endmodule
